// File: rtl/wb_commit_serializer_pkg.sv
// Shared types and constants for the writeback commit serializer.
// One FIFO entry holds a single retired register write.
package wb_commit_serializer_pkg;

    localparam int WB_FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } wb_entry_t;

    localparam wb_entry_t WB_ENTRY_ZERO = '{pc: 32'h0, rd: 5'h0, wdata: 32'h0};

    // Adds a 0..2 increment to a 32-bit counter, clamping at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] base, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/wb_commit_serializer_fifo.sv
// Two-write, one-read circular FIFO with first-word fall-through on the read side.
// Write port 0 always lands ahead of write port 1 in the same cycle.
module wb_fifo_2w1r
    import wb_commit_serializer_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          sys_clk,
    input  logic          resetn,
    input  logic          wr0_en,
    input  wb_entry_t     wr0_data,
    input  logic          wr1_en,
    input  wb_entry_t     wr1_data,
    input  logic          rd_en,
    output wb_entry_t     rd_data,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    wb_entry_t     mem_q [DEPTH];

    logic [AW-1:0] slot_a, slot_b;
    logic          we_a, we_b, pop;
    wb_entry_t     data_a;
    logic [1:0]    pushes;

    always_comb begin
        // A lone port-1 write takes the first free slot, not the second.
        slot_a  = wptr_q;
        slot_b  = wptr_q + AW'(1);
        we_a    = wr0_en | wr1_en;
        we_b    = wr0_en & wr1_en;
        data_a  = wr0_en ? wr0_data : wr1_data;
        pushes  = {1'b0, wr0_en} + {1'b0, wr1_en};
        pop     = rd_en && (count_q != '0);
        wptr_d  = wptr_q + AW'(pushes);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(pushes) - CW'(pop);
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an empty count hides stale contents.
    always_ff @(posedge sys_clk) begin
        if (we_a) mem_q[slot_a] <= data_a;
        if (we_b) mem_q[slot_b] <= wr1_data;
    end

    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;

endmodule

// File: rtl/wb_commit_serializer.sv
// Serializes a dual-issue writeback stream into a single-issue debug
// writeback port, counting retirements and flagging dropped writebacks.
module wb_commit_serializer
    import wb_commit_serializer_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        resetn,
    input  logic        in0_en,
    input  logic [4:0]  in0_rd,
    input  logic [31:0] in0_wdata,
    input  logic [31:0] in0_pc,
    input  logic        in1_en,
    input  logic [4:0]  in1_rd,
    input  logic [31:0] in1_wdata,
    input  logic [31:0] in1_pc,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_wen,
    output logic [31:0] retire_cnt,
    output logic        overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] occ;
    wb_entry_t     head, ent0, ent1;
    logic          room, acc0, acc1, push0, push1, pop, drop, have;
    logic [1:0]    n_acc;
    logic [31:0]   retire_cnt_q, retire_cnt_d;
    logic          overflow_q, overflow_d;

    always_comb begin
        // Room is judged on registered occupancy; a same-cycle pop earns nothing.
        room  = (occ <= CW'(DEPTH - 2));
        have  = (occ != '0);
        acc0  = resetn & in0_en & room;
        acc1  = resetn & in1_en & room;
        push0 = acc0 & (in0_rd != 5'd0);
        push1 = acc1 & (in1_rd != 5'd0);
        drop  = resetn & (in0_en | in1_en) & ~room;
        pop   = resetn & out_ready & have;
        n_acc = {1'b0, acc0} + {1'b0, acc1};
        ent0  = '{pc: in0_pc, rd: in0_rd, wdata: in0_wdata};
        ent1  = '{pc: in1_pc, rd: in1_rd, wdata: in1_wdata};

        retire_cnt_d = sat_add32(retire_cnt_q, n_acc);
        overflow_d   = overflow_q | drop;
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            retire_cnt_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    wb_fifo_2w1r #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .resetn   (resetn),
        .wr0_en   (push0),
        .wr0_data (ent0),
        .wr1_en   (push1),
        .wr1_data (ent1),
        .rd_en    (pop),
        .rd_data  (head),
        .count    (occ)
    );

    // Outputs are forced quiet while reset is held, before any edge has landed.
    always_comb begin
        in_ready   = ~resetn | room;
        out_valid  = resetn & have;
        out_wen    = out_valid ? 4'hF : 4'h0;
        out_pc     = out_valid ? head.pc    : 32'h0;
        out_rd     = out_valid ? head.rd    : 5'h0;
        out_wdata  = out_valid ? head.wdata : 32'h0;
        retire_cnt = resetn ? retire_cnt_q : 32'h0;
        overflow   = resetn & overflow_q;
    end

endmodule

// File: tb/tb_wb_commit_serializer.sv
// Randomized and directed bench for wb_commit_serializer against a
// queue-based reference model of the commit stream.
module tb_wb_commit_serializer;
    import wb_commit_serializer_pkg::*;

    localparam int DEPTH = 8;

    logic        sys_clk = 1'b0;
    logic        resetn  = 1'b0;
    logic        in0_en = 0, in1_en = 0;
    logic [4:0]  in0_rd = 0, in1_rd = 0;
    logic [31:0] in0_wdata = 0, in1_wdata = 0, in0_pc = 0, in1_pc = 0;
    logic        out_ready = 0;
    logic        in_ready, out_valid, overflow;
    logic [31:0] out_pc, out_wdata, retire_cnt;
    logic [4:0]  out_rd;
    logic [3:0]  out_wen;

    always #5 sys_clk = ~sys_clk;

    wb_commit_serializer #(.DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .resetn(resetn),
        .in0_en(in0_en), .in0_rd(in0_rd), .in0_wdata(in0_wdata), .in0_pc(in0_pc),
        .in1_en(in1_en), .in1_rd(in1_rd), .in1_wdata(in1_wdata), .in1_pc(in1_pc),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_wdata(out_wdata), .out_wen(out_wen),
        .retire_cnt(retire_cnt), .overflow(overflow)
    );

    int n_chk  = 0;
    int n_pass = 0;

    wb_entry_t   mq[$];
    logic [31:0] m_cnt = 0;
    logic        m_ovf = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: a commit stream is a queue; accepts need two free slots.
    task automatic model_edge();
        bit rdy;
        wb_entry_t e;
        if (!resetn) begin
            mq.delete();
            m_cnt = 0;
            m_ovf = 0;
            return;
        end
        rdy = (DEPTH - mq.size()) >= 2;
        if (out_ready && mq.size() != 0) void'(mq.pop_front());
        if (in0_en) begin
            if (rdy) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                e = '{pc: in0_pc, rd: in0_rd, wdata: in0_wdata};
                if (in0_rd != 0) mq.push_back(e);
            end else m_ovf = 1;
        end
        if (in1_en) begin
            if (rdy) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                e = '{pc: in1_pc, rd: in1_rd, wdata: in1_wdata};
                if (in1_rd != 0) mq.push_back(e);
            end else m_ovf = 1;
        end
    endtask

    task automatic check_outputs();
        bit v;
        wb_entry_t h;
        v = resetn && mq.size() != 0;
        h = v ? mq[0] : WB_ENTRY_ZERO;
        chk("out_valid",  out_valid, v);
        chk("out_wen",    out_wen, v ? 4'hF : 4'h0);
        chk("out_pc",     out_pc, h.pc);
        chk("out_rd",     out_rd, h.rd);
        chk("out_wdata",  out_wdata, h.wdata);
        chk("in_ready",   in_ready, !resetn || (DEPTH - mq.size()) >= 2);
        chk("retire_cnt", retire_cnt, resetn ? m_cnt : 32'h0);
        chk("overflow",   overflow, resetn ? m_ovf : 1'b0);
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit e0, input logic [4:0] r0, input logic [31:0] p0, input logic [31:0] w0,
                         input bit e1, input logic [4:0] r1, input logic [31:0] p1, input logic [31:0] w1,
                         input bit ordy);
        in0_en = e0; in0_rd = r0; in0_pc = p0; in0_wdata = w0;
        in1_en = e1; in1_rd = r1; in1_pc = p1; in1_wdata = w1;
        out_ready = ordy;
    endtask

    task automatic idle(input bit ordy);
        drive(0, 0, 0, 0, 0, 0, 0, 0, ordy);
    endtask

    initial begin
        // Reset and idle
        resetn = 0;
        idle(0);
        #1;
        check_outputs();
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1'b1);
        resetn = 1;

        // Dual push ordering
        drive(1, 2, 32'hbfc00000, 32'h11, 1, 3, 32'hbfc00004, 32'h22, 1);
        step();
        chk("dual_pc0", out_pc, 32'hbfc00000);
        chk("dual_rd0", out_rd, 5'd2);
        chk("dual_wd0", out_wdata, 32'h11);
        chk("dual_cnt", retire_cnt, 32'd2);
        idle(1);
        step();
        chk("dual_pc1", out_pc, 32'hbfc00004);
        chk("dual_rd1", out_rd, 5'd3);
        chk("dual_wd1", out_wdata, 32'h22);
        step();
        chk("dual_empty", out_valid, 1'b0);

        // rd=0 filtering
        drive(1, 0, 32'h100, 32'hdead, 1, 5, 32'h104, 32'hbeef, 1);
        step();
        chk("filt_rd", out_rd, 5'd5);
        chk("filt_cnt", retire_cnt, 32'd4);
        idle(1);
        step();
        chk("filt_empty", out_valid, 1'b0);

        // Backpressure and full
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(i + 1), 32'h200 + 8 * i, 32'(i), 1, 5'(i + 10), 32'h204 + 8 * i, 32'(i + 100), 0);
            step();
        end
        chk("full_in_ready", in_ready, 1'b0);
        drive(1, 7, 32'h300, 32'h1, 1, 8, 32'h304, 32'h2, 0);
        step();
        chk("full_ovf", overflow, 1'b1);
        chk("full_cnt", retire_cnt, 32'd12);
        idle(1);
        repeat (8) step();
        chk("full_drained", out_valid, 1'b0);
        chk("full_ovf_sticky", overflow, 1'b1);
        resetn = 0;
        step();
        resetn = 1;

        // Wrap-around: walk write pointer to 7 with occupancy 1, then dual push
        for (int i = 0; i < 7; i++) begin
            drive(1, 5'(i + 1), 32'h400 + 4 * i, 32'(i + 50), 0, 0, 0, 0, 1);
            step();
        end
        drive(1, 20, 32'h500, 32'haaaa, 1, 21, 32'h504, 32'hbbbb, 0);
        step();
        idle(1);
        step();
        chk("wrap_pc_a", out_pc, 32'h500);
        step();
        chk("wrap_pc_b", out_pc, 32'h504);
        step();
        chk("wrap_empty", out_valid, 1'b0);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(i + 3), 32'h600 + 4 * i, 32'(i), 0, 0, 0, 0, 0);
            step();
        end
        resetn = 0;
        idle(0);
        #1;
        chk("midrst_valid_now", out_valid, 1'b0);
        step();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_cnt", retire_cnt, 32'd0);
        resetn = 1;
        idle(1);
        repeat (3) step();
        chk("midrst_stale", out_valid, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in0_en    = ($urandom_range(0, 9) < 6);
            in1_en    = ($urandom_range(0, 9) < 5);
            in0_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in1_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in0_pc    = $urandom;
            in1_pc    = $urandom;
            in0_wdata = $urandom;
            in1_wdata = $urandom;
            out_ready = ($urandom_range(0, 9) < ((c / 300) % 2 == 0 ? 7 : 3));
            resetn    = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
